// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: collects WIDTH qualified bits after a start strobe into one word.
// Word is presented 1 clk after its last bit; a completed word is dropped (ovr set) while the previous one is unconsumed.
module sipo_rx #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             s_in,
   input  logic             s_valid,
   output logic [WIDTH-1:0] p_out,
   output logic             p_valid,
   input  logic             p_ready,
   output logic             busy,
   output logic             ovr,
   input  logic             ovr_clr
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt, base_cnt;
   logic [WIDTH-1:0] sr, sr_nxt, base_sr, shifted;
   logic             done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         sr    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         sr    <= sr_nxt;
      end
   end

   // A start strobe restarts from an empty word, so the shift source is zero in that cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sr_nxt    = sr;
      done      = 1'b0;
      base_sr   = start ? '0 : sr;
      base_cnt  = start ? '0 : cnt;
      shifted   = (MSB_FIRST != 0) ? {base_sr[WIDTH-2:0], s_in}
                                   : {s_in, base_sr[WIDTH-1:1]};
      if (start) begin
         state_nxt = SHIFT;
         sr_nxt    = s_valid ? shifted : '0;
         cnt_nxt   = s_valid ? base_cnt + CNT_ONE : '0;
      end else if (state == SHIFT && s_valid) begin
         sr_nxt  = shifted;
         cnt_nxt = cnt + CNT_ONE;
         if (cnt == CNT_LAST) begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_out   <= '0;
         p_valid <= 1'b0;
         ovr     <= 1'b0;
      end else begin
         if (done && (!p_valid || p_ready)) begin
            p_out   <= shifted;
            p_valid <= 1'b1;
         end else if (p_valid && p_ready) begin
            p_valid <= 1'b0;
         end
         // Overrun set wins over a simultaneous clear.
         if (done && p_valid && !p_ready)
            ovr <= 1'b1;
         else if (ovr_clr)
            ovr <= 1'b0;
      end
   end

   assign busy = (state == SHIFT);

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: MSB-first and LSB-first instances checked against a bit-queue reference model.
module tb_sipo_rx;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0, s_in = 1'b0, s_valid = 1'b0, p_ready = 1'b0, ovr_clr = 1'b0;
   logic [W-1:0] p_out_m, p_out_l;
   logic p_valid_m, p_valid_l, busy_m, busy_l, ovr_m, ovr_l;

   always #5 clk = ~clk;

   sipo_rx #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .start(start), .s_in(s_in), .s_valid(s_valid),
      .p_out(p_out_m), .p_valid(p_valid_m), .p_ready(p_ready),
      .busy(busy_m), .ovr(ovr_m), .ovr_clr(ovr_clr));

   sipo_rx #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .start(start), .s_in(s_in), .s_valid(s_valid),
      .p_out(p_out_l), .p_valid(p_valid_l), .p_ready(p_ready),
      .busy(busy_l), .ovr(ovr_l), .ovr_clr(ovr_clr));

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: the bits of the current frame in arrival order.
   bit           q[$];
   bit           act = 1'b0;
   logic [W-1:0] e_out_m = '0, e_out_l = '0;
   bit           e_pv = 1'b0, e_ovr = 1'b0;

   function automatic logic [W-1:0] frame_word(input bit msb);
      logic [W-1:0] w = '0;
      for (int i = 0; i < W; i++)
         if (msb) w[W-1-i] = q[i];
         else     w[i]     = q[i];
      return w;
   endfunction

   task automatic model_reset();
      q.delete();
      act = 1'b0; e_out_m = '0; e_out_l = '0; e_pv = 1'b0; e_ovr = 1'b0;
   endtask

   task automatic model_step();
      bit done = 1'b0;
      bit set_ovr;
      if (start) begin
         q.delete();
         act = 1'b1;
         if (s_valid) q.push_back(s_in);
      end else if (act && s_valid) begin
         q.push_back(s_in);
         if (q.size() == W) begin
            done = 1'b1;
            act  = 1'b0;
         end
      end
      set_ovr = done && e_pv && !p_ready;
      if (done && (!e_pv || p_ready)) begin
         e_out_m = frame_word(1'b1);
         e_out_l = frame_word(1'b0);
         e_pv    = 1'b1;
      end else if (e_pv && p_ready) begin
         e_pv = 1'b0;
      end
      if (set_ovr) e_ovr = 1'b1;
      else if (ovr_clr) e_ovr = 1'b0;
   endtask

   task automatic compare_all();
      check("p_out_msb", p_out_m, e_out_m);
      check("p_out_lsb", p_out_l, e_out_l);
      check("p_valid_msb", p_valid_m, e_pv);
      check("p_valid_lsb", p_valid_l, e_pv);
      check("busy_msb", busy_m, act);
      check("busy_lsb", busy_l, act);
      check("ovr_msb", ovr_m, e_ovr);
      check("ovr_lsb", ovr_l, e_ovr);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic drive(input logic st, input logic b, input logic v);
      start = st; s_in = b; s_valid = v;
      tick();
      start = 1'b0; s_valid = 1'b0;
   endtask

   // Sends a word MSB-of-argument first, with 'gap' idle cycles between bits.
   task automatic send_word(input logic [W-1:0] w, input int gap, input logic rdy_last);
      for (int i = 0; i < W; i++) begin
         if (i == W - 1) p_ready = rdy_last;
         drive(i == 0, w[W-1-i], 1'b1);
         if (i != W - 1)
            for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0);
      end
      p_ready = 1'b0;
   endtask

   task automatic async_reset_pulse(input string tag);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check({tag, "_pout"}, {p_out_m, p_out_l}, '0);
      check({tag, "_flags"}, {p_valid_m, busy_m, ovr_m, p_valid_l, busy_l, ovr_l}, '0);
      #1 rst = 1'b0;
   endtask

   task automatic consume();
      p_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      p_ready = 1'b0;
   endtask

   initial begin
      #3 rst = 1'b1;
      #1;
      check("reset_pout", {p_out_m, p_out_l}, '0);
      check("reset_flags", {p_valid_m, busy_m, ovr_m, p_valid_l, busy_l, ovr_l}, '0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();

      // Basic frame, back-to-back bits
      send_word(4'b1011, 0, 1'b0);
      check("basic_msb", p_out_m, 4'b1011);
      check("basic_lsb", p_out_l, 4'b1101);
      check("basic_pv", p_valid_m, 1'b1);
      check("basic_busy", busy_m, 1'b0);
      consume();
      check("consumed_pv", p_valid_m, 1'b0);

      // Same word with two idle cycles between bits
      send_word(4'b1011, 2, 1'b0);
      check("gap_msb", p_out_m, 4'b1011);
      check("gap_lsb", p_out_l, 4'b1101);

      // Overrun: second word completes while first is pending
      send_word(4'b0110, 0, 1'b0);
      check("ovr_keep", p_out_m, 4'b1011);
      check("ovr_set", ovr_m, 1'b1);
      ovr_clr = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      ovr_clr = 1'b0;
      check("ovr_clr", ovr_m, 1'b0);

      // Consume and replace on the same cycle
      send_word(4'b0110, 0, 1'b1);
      check("replace_pout", p_out_m, 4'b0110);
      check("replace_pv", p_valid_m, 1'b1);
      check("replace_ovr", ovr_m, 1'b0);
      consume();

      // Restart mid-frame discards the partial word
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      send_word(4'b0001, 0, 1'b0);
      check("restart_pout", p_out_m, 4'b0001);
      check("restart_ovr", ovr_m, 1'b0);
      consume();

      // Async reset between edges mid-capture, then bits without start
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      async_reset_pulse("midrst");
      for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b1);
      check("norestart_pv", p_valid_m, 1'b0);
      check("norestart_busy", busy_m, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         start   = ($urandom_range(0, 9) == 0);
         s_valid = ($urandom_range(0, 9) < 7);
         s_in    = $urandom_range(0, 1);
         p_ready = ($urandom_range(0, 9) < 3);
         ovr_clr = ($urandom_range(0, 19) == 0);
         tick();
         if ($urandom_range(0, 299) == 0) async_reset_pulse("rand_rst");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, word length in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 means the first received bit lands in p_out[WIDTH-1], 0 means it lands in p_out[0].
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, frame-start strobe; begins a new word capture.
REQ-006 SHALL have port s_in, input, 1, serial data bit.
REQ-007 SHALL have port s_valid, input, 1, qualifies s_in for the current cycle.
REQ-008 SHALL have port p_out, output, WIDTH, assembled parallel word (holding register).
REQ-009 SHALL have port p_valid, output, 1, p_out holds an unconsumed word.
REQ-010 SHALL have port p_ready, input, 1, consumer accepts p_out when p_valid=1.
REQ-011 SHALL have port busy, output, 1, capture in progress (state SHIFT).
REQ-012 SHALL have port ovr, output, 1, sticky overrun flag.
REQ-013 SHALL have port ovr_clr, input, 1, synchronous clear of ovr.

Function
REQ-014 SHALL implement two states, IDLE and SHIFT, plus a bit counter cnt of width clog2(WIDTH+1) and a shift register sr[WIDTH-1:0].
REQ-015 IDLE: s_valid ignored; start=1 -> SHIFT with cnt cleared to 0 and sr cleared to 0.
REQ-016 start=1 with s_valid=1 in the same cycle: s_in SHALL be captured as bit 0 of the new word (cnt becomes 1).
REQ-017 SHIFT: each cycle with s_valid=1 SHALL shift s_in into sr (MSB_FIRST=1: sr <= {sr[WIDTH-2:0], s_in}; MSB_FIRST=0: sr <= {s_in, sr[WIDTH-1:1]}) and increment cnt; s_valid=0 holds sr and cnt.
REQ-018 start=1 while in SHIFT SHALL discard the partial word and restart per REQ-015/REQ-016; no p_valid and no ovr result from the discarded word.
REQ-019 Completion: the cycle accepting the WIDTH-th bit SHALL form word W (sr with that bit applied) and return the block to IDLE, unless start=1 in that cycle (REQ-018 wins).
REQ-020 On completion with p_valid=0, or p_valid=1 and p_ready=1 in the same cycle, p_out SHALL load W and p_valid SHALL be 1 on the next cycle (latency: 1 clock after the last bit edge).
REQ-021 On completion with p_valid=1 and p_ready=0, W SHALL be dropped, p_out SHALL be unchanged, and ovr SHALL set to 1.
REQ-022 p_valid=1, p_ready=1, no completion: p_valid SHALL clear next cycle; p_out keeps its value.
REQ-023 p_ready with p_valid=0 SHALL have no effect.
REQ-024 ovr_clr=1 SHALL clear ovr; a simultaneous set (REQ-021) SHALL take priority, leaving ovr=1.
REQ-025 busy SHALL equal 1 exactly while the state is SHIFT.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, cnt=0, sr=0, p_out=0, p_valid=0, busy=0, ovr=0.
REQ-027 rst asserted mid-capture SHALL discard the partial word; after release, no word is produced until the next start.
REQ-028 Operation SHALL resume on the first rising clk edge after rst deasserts.

Verification (WIDTH=4, MSB_FIRST=1 unless noted)
REQ-029 start+s_valid with bits 1,0,1,1 on 4 consecutive cycles, p_ready=0 -> p_out=4'b1011, p_valid=1 one cycle after the 4th bit, busy=0.
REQ-030 Same bits with MSB_FIRST=0 -> p_out=4'b1101; bits with s_valid gaps of 2 idle cycles -> identical result.
REQ-031 Word 4'b1011 pending, p_ready=0, second word 4'b0110 completes -> p_out stays 4'b1011, ovr=1; ovr_clr pulse -> ovr=0.
REQ-032 Word pending with p_ready=1 on the same cycle the second word 4'b0110 completes -> p_out=4'b0110, p_valid stays 1, ovr=0.
REQ-033 Two bits 1,1 then start with bits 0,0,0,1 -> single word 4'b0001, no overrun.
REQ-034 rst pulsed between clk edges after 2 bits -> all outputs 0 immediately; subsequent s_valid without start -> no word produced.
